mem_port_multi: RTL and testbench

Memory access unit for the multicycle RISC-V core, directly downstream of the multicycle control FSM. Consumes its IorD/MemRead/MemWrite/IRWrite strobes, runs one bus transaction per request against a wait-state memory, and holds the Instruction Register and Memory Data Register. Returns the opcode field to the control FSM and raises a stall so the FSM holds its state until the access completes.

---
 rtl/mem_port_multi.sv | 155 +++++++++++++++
 tb/tb_mem_port_multi.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_multi.sv
// Memory access unit: one wait-state bus transaction per control-FSM request; owns IR and MDR.
// Latency: request cycle + WAIT (>=1 cycle, until iBusReady) + DONE; oStall holds the FSM throughout.
module mem_port_multi (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [31:0] iPC,
  input  logic [31:0] iALUOut,
  input  logic [31:0] iRegB,
  input  logic        iIorD,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic        iIRWrite,
  output logic [31:0] oIR,
  output logic [6:0]  oOp,
  output logic [31:0] oMDR,
  output logic        oStall,
  output logic        oAccessFault,
  output logic [31:0] oBusAddr,
  output logic [31:0] oBusWData,
  output logic [3:0]  oBusBE,
  output logic        oBusRead,
  output logic        oBusWrite,
  input  logic [31:0] iBusRData,
  input  logic        iBusReady
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  // What the load extender needs once the bus answers.
  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] lane;
  } acc_t;

  state_t      state;
  acc_t        acc_q;
  logic        req;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic        illegal;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign req    = iMemRead | iMemWrite;
  assign addr   = iIorD ? iALUOut : iPC;
  assign funct3 = iIorD ? oIR[14:12] : 3'b010;
  assign oOp    = oIR[6:0];
  assign oStall = ((state == S_IDLE) && req) || (state == S_WAIT);

  always_comb begin
    illegal = 1'b0;
    case (funct3[1:0])
      2'b00:   illegal = 1'b0;
      2'b01:   illegal = addr[0];
      2'b10:   illegal = (addr[1:0] != 2'b00);
      default: illegal = 1'b1;
    endcase
    if (iIorD && ((funct3 == 3'b110) || (funct3 == 3'b111)))
      illegal = 1'b1;
  end

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = iRegB;
    case (funct3[1:0])
      2'b00: begin
        st_be    = 4'b0001 << addr[1:0];
        st_wdata = {4{iRegB[7:0]}};
      end
      2'b01: begin
        st_be    = addr[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{iRegB[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = iRegB;
      end
    endcase
  end

  always_comb begin
    ld_byte = iBusRData[7:0];
    case (acc_q.lane)
      2'd0: ld_byte = iBusRData[7:0];
      2'd1: ld_byte = iBusRData[15:8];
      2'd2: ld_byte = iBusRData[23:16];
      2'd3: ld_byte = iBusRData[31:24];
      default: ld_byte = iBusRData[7:0];
    endcase
    ld_half = acc_q.lane[1] ? iBusRData[31:16] : iBusRData[15:0];
    case (acc_q.funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h000000, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0000, ld_half};
      default: ld_data = iBusRData;
    endcase
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state        <= S_IDLE;
      acc_q        <= '0;
      oIR          <= 32'h00000013;
      oMDR         <= 32'h0;
      oAccessFault <= 1'b0;
      oBusAddr     <= 32'h0;
      oBusWData    <= 32'h0;
      oBusBE       <= 4'b0000;
      oBusRead     <= 1'b0;
      oBusWrite    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req) begin
            if (illegal) begin
              oAccessFault <= 1'b1;
              state        <= S_DONE;
            end else begin
              oBusAddr <= {addr[31:2], 2'b00};
              acc_q    <= '{funct3: funct3, lane: addr[1:0]};
              // A simultaneous read request is dropped: the write takes the bus.
              if (iMemWrite) begin
                oBusWrite <= 1'b1;
                oBusBE    <= st_be;
                oBusWData <= st_wdata;
              end else begin
                oBusRead <= 1'b1;
                oBusBE   <= 4'b0000;
              end
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (iBusReady) begin
            oBusRead  <= 1'b0;
            oBusWrite <= 1'b0;
            if (oBusRead) begin
              if (iIRWrite) oIR <= iBusRData;
              else          oMDR <= ld_data;
            end
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_multi.sv
// Scoreboard bench for mem_port_multi: driver predicts each access, monitors compare at bus and completion.
module tb_mem_port_multi;

  logic        iCLK = 1'b0;
  logic        iRST = 1'b1;
  logic [31:0] iPC = '0, iALUOut = '0, iRegB = '0;
  logic        iIorD = 1'b0, iMemRead = 1'b0, iMemWrite = 1'b0, iIRWrite = 1'b0;
  logic [31:0] oIR, oMDR, oBusAddr, oBusWData;
  logic [6:0]  oOp;
  logic        oStall, oAccessFault, oBusRead, oBusWrite;
  logic [3:0]  oBusBE;
  logic [31:0] iBusRData = '0;
  logic        iBusReady = 1'b0;

  mem_port_multi dut (
    .iCLK(iCLK), .iRST(iRST), .iPC(iPC), .iALUOut(iALUOut), .iRegB(iRegB),
    .iIorD(iIorD), .iMemRead(iMemRead), .iMemWrite(iMemWrite), .iIRWrite(iIRWrite),
    .oIR(oIR), .oOp(oOp), .oMDR(oMDR), .oStall(oStall), .oAccessFault(oAccessFault),
    .oBusAddr(oBusAddr), .oBusWData(oBusWData), .oBusBE(oBusBE),
    .oBusRead(oBusRead), .oBusWrite(oBusWrite), .iBusRData(iBusRData), .iBusReady(iBusReady)
  );

  always #5 iCLK = ~iCLK;

  typedef struct {
    logic [31:0] ir, mdr, addr, wdata;
    logic        fault, bus, rd, wr;
    logic [3:0]  be;
    int          stall;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          checks = 0, failures = 0;
  int          stall_cnt = 0, wcnt = 0, cur_waits = 0;
  logic [31:0] cur_rdata = '0;
  logic        mon_en = 1'b0, spur_en = 1'b0, force_pulse = 1'b0;
  logic [31:0] ir_m = 32'h00000013, mdr_m = 32'h0;
  logic        fault_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [2:0] f3, input int off);
    logic [31:0] s;
    s = d >> (8 * off);
    case (f3)
      3'b000:  return 32'($signed(s[7:0]));
      3'b100:  return {24'h0, s[7:0]};
      3'b001:  return 32'($signed(s[15:0]));
      3'b101:  return {16'h0, s[15:0]};
      default: return d;
    endcase
  endfunction

  // Bus slave: ready after cur_waits extra cycles; optional stray ready pulses while idle.
  always @(posedge iCLK) begin
    #1;
    if (force_pulse) begin
      iBusReady = 1'b1;
      iBusRData = 32'hDEADBEEF;
    end else if (oBusRead || oBusWrite) begin
      if (wcnt >= cur_waits) begin
        iBusReady = 1'b1;
        iBusRData = cur_rdata;
        wcnt = 0;
      end else begin
        iBusReady = 1'b0;
        iBusRData = $urandom;
        wcnt++;
      end
    end else begin
      iBusReady = spur_en && ($urandom_range(0, 3) == 0);
      iBusRData = $urandom;
      wcnt = 0;
    end
  end

  // Monitor: bus attributes during every strobe cycle, register state on completion.
  always @(negedge iCLK) begin
    if (!mon_en || iRST) begin
      stall_cnt = 0;
    end else begin
      if (oBusRead || oBusWrite) begin
        if (exp_q.size() == 0) begin
          chk("bus_without_request", 32'(oBusRead | oBusWrite), 32'h0);
        end else begin
          mon_e = exp_q[0];
          chk("bus_expected", 32'h1, 32'(mon_e.bus));
          chk("bus_addr", oBusAddr, mon_e.addr);
          chk("bus_read", 32'(oBusRead), 32'(mon_e.rd));
          chk("bus_write", 32'(oBusWrite), 32'(mon_e.wr));
          chk("bus_be", 32'(oBusBE), 32'(mon_e.be));
          if (mon_e.wr) chk("bus_wdata", oBusWData, mon_e.wdata);
        end
      end
      if (iMemRead || iMemWrite) begin
        if (oStall) begin
          stall_cnt++;
        end else if (exp_q.size() == 0) begin
          chk("completion_without_expectation", 32'h1, 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("ir", oIR, mon_e.ir);
          chk("op", 32'(oOp), 32'(mon_e.ir[6:0]));
          chk("mdr", oMDR, mon_e.mdr);
          chk("fault", 32'(oAccessFault), 32'(mon_e.fault));
          chk("stall_cycles", 32'(stall_cnt), 32'(mon_e.stall));
          chk("strobes_in_done", 32'({oBusRead, oBusWrite}), 32'h0);
          stall_cnt = 0;
        end
      end
    end
  end

  // Issue one request, predict its outcome, hold it until the DUT releases the stall.
  task automatic access(input logic iord, input logic rd, input logic wr, input logic irw,
                        input logic [31:0] a, input logic [31:0] regb, input logic [31:0] rdata,
                        input int waits, input int idle);
    exp_t        e;
    logic [2:0]  f3;
    int          nb, off, n;
    logic        bad;
    f3  = iord ? ir_m[14:12] : 3'b010;
    nb  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off = int'(a[1:0]);
    bad = (f3[1:0] == 2'b11) || (iord && (f3 >= 3'b110)) || ((off % nb) != 0);
    e.bus   = !bad;
    e.wr    = wr;
    e.rd    = rd && !wr;
    e.addr  = a & ~32'h3;
    e.be    = 4'b0000;
    e.wdata = 32'h0;
    e.stall = bad ? 1 : waits + 2;
    if (bad) begin
      fault_m = 1'b1;
    end else if (wr) begin
      e.be    = 4'(((1 << nb) - 1) << off);
      e.wdata = (nb == 1) ? {4{regb[7:0]}} : (nb == 2) ? {2{regb[15:0]}} : regb;
    end else if (irw) begin
      ir_m = rdata;
    end else begin
      mdr_m = load_ext(rdata, f3, off);
    end
    e.ir    = ir_m;
    e.mdr   = mdr_m;
    e.fault = fault_m;
    exp_q.push_back(e);
    cur_waits = waits;
    cur_rdata = rdata;
    iIorD     = iord;
    iPC       = iord ? $urandom : a;
    iALUOut   = iord ? a : $urandom;
    iRegB     = regb;
    iMemRead  = rd;
    iMemWrite = wr;
    iIRWrite  = irw;
    n = 0;
    do begin
      @(negedge iCLK);
      n++;
    end while (oStall && n < 100);
    if (oStall) chk("stall_timeout", 32'(oStall), 32'h0);
    @(posedge iCLK);
    #1;
    iMemRead  = 1'b0;
    iMemWrite = 1'b0;
    iIRWrite  = 1'b0;
    repeat (idle) begin
      @(posedge iCLK);
      #1;
    end
  endtask

  initial begin
    int n;
    logic [31:0] rnd;
    repeat (3) @(posedge iCLK);
    @(negedge iCLK) iRST = 1'b0;
    @(negedge iCLK);
    chk("rst_ir", oIR, 32'h00000013);
    chk("rst_op", 32'(oOp), 32'h13);
    chk("rst_mdr", oMDR, 32'h0);
    chk("rst_stall", 32'(oStall), 32'h0);
    chk("rst_fault", 32'(oAccessFault), 32'h0);
    chk("rst_bus_addr", oBusAddr, 32'h0);
    chk("rst_bus_wdata", oBusWData, 32'h0);
    chk("rst_bus_ctl", 32'({oBusBE, oBusRead, oBusWrite}), 32'h0);
    @(posedge iCLK);
    #1;
    mon_en  = 1'b1;
    spur_en = 1'b1;

    access(0, 1, 0, 1, 32'h100, 0, 32'h00500093, 0, 1);
    access(0, 1, 0, 1, 32'h104, 0, 32'h00000003, 1, 0);
    access(1, 1, 0, 0, 32'h203, 0, 32'h80FFFF00, 3, 0);
    access(0, 1, 0, 1, 32'h108, 0, 32'h00004003, 0, 0);
    access(1, 1, 0, 0, 32'h203, 0, 32'h80FFFF00, 3, 2);
    access(0, 1, 0, 1, 32'h10C, 0, 32'h00001023, 2, 0);
    access(1, 0, 1, 0, 32'h202, 32'h1234ABCD, 0, 0, 0);
    access(1, 1, 1, 0, 32'h202, 32'h1234ABCD, 32'h55555555, 1, 0);
    access(0, 1, 0, 1, 32'h110, 0, 32'h00002003, 0, 0);
    access(1, 1, 0, 0, 32'h201, 0, 32'hCAFEF00D, 2, 1);
    access(1, 1, 0, 0, 32'h204, 0, 32'hCAFEF00D, 0, 0);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);

    // Reset in the middle of a long fetch; a later ready must not land anywhere.
    mon_en    = 1'b0;
    spur_en   = 1'b0;
    cur_waits = 20;
    cur_rdata = 32'h11111111;
    iIorD     = 1'b0;
    iPC       = 32'h40;
    iMemRead  = 1'b1;
    iIRWrite  = 1'b1;
    n = 0;
    do begin
      @(negedge iCLK);
      n++;
    end while (!oBusRead && n < 20);
    chk("mid_wait_strobe_seen", 32'(oBusRead), 32'h1);
    @(negedge iCLK);
    iRST      = 1'b1;
    iMemRead  = 1'b0;
    iIRWrite  = 1'b0;
    #1;
    chk("arst_strobe_drop", 32'({oBusRead, oBusWrite}), 32'h0);
    chk("arst_ir", oIR, 32'h00000013);
    chk("arst_fault", 32'(oAccessFault), 32'h0);
    @(negedge iCLK) iRST = 1'b0;
    force_pulse = 1'b1;
    @(negedge iCLK) force_pulse = 1'b0;
    @(negedge iCLK);
    chk("post_rst_ir", oIR, 32'h00000013);
    chk("post_rst_mdr", oMDR, 32'h0);
    chk("post_rst_strobes", 32'({oBusRead, oBusWrite}), 32'h0);
    chk("post_rst_stall", 32'(oStall), 32'h0);
    ir_m    = 32'h00000013;
    mdr_m   = 32'h0;
    fault_m = 1'b0;
    @(posedge iCLK);
    #1;
    mon_en  = 1'b1;
    spur_en = 1'b1;

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        rnd = $urandom & ~32'h3;
        if ($urandom_range(0, 7) == 0) rnd = rnd | 32'h2;
        access(0, 1, 0, 1, rnd, 0, $urandom, $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        case ($urandom_range(0, 2))
          0: access(1, 1, 0, 0, $urandom_range(0, 255), $urandom, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 2));
          1: access(1, 0, 1, 0, $urandom_range(0, 255), $urandom, $urandom,
                    $urandom_range(0, 4), $urandom_range(0, 2));
          default: access(1, 1, 1, 0, $urandom_range(0, 255), $urandom, $urandom,
                          $urandom_range(0, 4), $urandom_range(0, 2));
        endcase
      end
    end
    repeat (2) @(posedge iCLK);
    chk("final_queue_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
